// File: rtl/matrix_acc_ctrl.sv
// matrix_acc_ctrl: operand/accumulator sequencer and row-drain front end for the matrix_mul outer-product unit
`ifndef MATRIX_MUL
`define MATRIX_MUL 4'b0001
`endif
module matrix_acc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      op_A,
  input  logic [31:0]      op_B,
  output logic [3:0]       mul_ctrl_o,
  output logic [31:0]      op_A_o,
  output logic [31:0]      op_B_o,
  output logic [127:0]     M_o,
  input  logic [127:0]     mul_res_i,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic [1:0]       rd_idx,
  output logic             busy,
  output logic [CNT_W-1:0] mac_cnt
);
  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;
  localparam logic [1:0] OP_MAC = 2'b00, OP_CLR = 2'b01;
  state_t state, state_nx;
  logic [31:0] m [4];
  logic clr_q, acc, beat, last, zero;
  assign acc  = cmd_valid & (state == IDLE);
  assign beat = (state == DRAIN) & rd_ready;
  assign last = beat & (rd_idx == 2'd3);
  assign zero = (acc & (cmd_op == OP_CLR)) | (last & clr_q);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE && acc) ? (cmd_op == OP_MAC ? MAC : cmd_op == OP_CLR ? IDLE : DRAIN) :
               (state == MAC || last) ? IDLE : state;
  always_comb begin
    cmd_ready  = state == IDLE;
    busy       = state != IDLE;
    rd_valid   = state == DRAIN;
    mul_ctrl_o = state == MAC ? `MATRIX_MUL : 4'b0000;
    rd_data    = m[rd_idx];
  end
  for (genvar i = 0; i < 4; i++) begin : g_tile
    assign M_o[32*i +: 32] = m[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m[i] <= '0;
      op_A_o  <= '0;
      op_B_o  <= '0;
      mac_cnt <= '0;
      rd_idx  <= '0;
      clr_q   <= 1'b0;
    end else begin
      if (acc && cmd_op == OP_MAC) begin
        op_A_o <= op_A;
        op_B_o <= op_B;
      end
      if (acc && cmd_op[1]) begin
        rd_idx <= '0;
        clr_q  <= cmd_op[0];
      end
      if (beat) rd_idx <= rd_idx + 2'd1;
      if (state == MAC) begin
        for (int i = 0; i < 4; i++) m[i] <= mul_res_i[32*i +: 32];
        mac_cnt <= mac_cnt + {{(CNT_W-1){1'b0}}, ~&mac_cnt};
      end
      if (zero) begin
        for (int i = 0; i < 4; i++) m[i] <= '0;
        mac_cnt <= '0;
      end
    end
  end
endmodule
